// File: rtl/iir_tdm.sv
// Time-multiplexed multi-channel direct-form-I IIR filter built around one shared multiplier.
// Products are registered and accumulated one cycle later; history is per channel, coefficients are shared.
module iir_tdm #(
   parameter  int DATA_WIDTH = 32,
   parameter  int NUM_CH     = 2,
   parameter  int ORDER      = 1,
   parameter  int QUANT_BITS = 10,
   localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
   localparam int SEL_W      = $clog2(2*ORDER+1)
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [CH_W-1:0]       in_channel,
   input  logic [DATA_WIDTH-1:0] din,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [CH_W-1:0]       out_channel,
   output logic [DATA_WIDTH-1:0] dout,
   input  logic                  coef_we,
   input  logic [SEL_W-1:0]      coef_sel,
   input  logic [DATA_WIDTH-1:0] coef_wdata
);

   localparam int NTAP  = 2*ORDER + 1;
   localparam int TAP_W = $clog2(NTAP + 1);
   localparam int PW    = 2*DATA_WIDTH;

   typedef enum logic [1:0] {S_IDLE, S_MAC, S_DONE} state_t;

   state_t                        r_state;
   logic signed [DATA_WIDTH-1:0]  r_coef [NTAP];
   logic signed [DATA_WIDTH-1:0]  r_xh   [NUM_CH][ORDER];
   logic signed [DATA_WIDTH-1:0]  r_yh   [NUM_CH][ORDER];
   logic signed [DATA_WIDTH-1:0]  r_x;
   logic signed [DATA_WIDTH-1:0]  r_acc;
   logic signed [DATA_WIDTH-1:0]  r_prod;
   logic                          r_prod_neg;
   logic [CH_W-1:0]               r_ch;
   logic [TAP_W-1:0]              r_tap;

   logic signed [DATA_WIDTH-1:0]  w_coef;
   logic signed [DATA_WIDTH-1:0]  w_op;
   logic signed [PW-1:0]          w_prod;
   logic signed [DATA_WIDTH-1:0]  w_dq;
   logic signed [DATA_WIDTH-1:0]  w_acc_next;

   // Tap order: b0 uses x[n], b1..bN use x history, a1..aN use y history.
   always_comb begin
      // NOTE: defaults first so every path assigns; otherwise a latch is inferred.
      w_coef = r_coef[0];
      w_op   = r_x;
      for (int k = 1; k < NTAP; k++)
         if (r_tap == TAP_W'(k)) w_coef = r_coef[k];
      for (int k = 1; k <= ORDER; k++) begin
         if (r_tap == TAP_W'(k))         w_op = r_xh[r_ch][k-1];
         if (r_tap == TAP_W'(ORDER + k)) w_op = r_yh[r_ch][k-1];
      end
   end

   assign w_prod     = PW'(w_coef) * PW'(w_op);
   assign w_dq       = DATA_WIDTH'(w_prod >>> QUANT_BITS);
   assign w_acc_next = r_prod_neg ? (r_acc - r_prod) : (r_acc + r_prod);

   always_ff @(posedge clock) begin
      // NOTE: sequential state uses non-blocking assignments only.
      if (reset) begin
         r_state     <= S_IDLE;
         in_ready    <= 1'b1;
         out_valid   <= 1'b0;
         out_channel <= '0;
         dout        <= '0;
         r_x         <= '0;
         r_acc       <= '0;
         r_prod      <= '0;
         r_prod_neg  <= 1'b0;
         r_ch        <= '0;
         r_tap       <= '0;
         // NOTE: coefficient and history arrays are reset explicitly; filter state must restart clean.
         for (int k = 0; k < NTAP; k++) r_coef[k] <= '0;
         r_coef[0]       <= DATA_WIDTH'(179);
         r_coef[1]       <= DATA_WIDTH'(179);
         r_coef[ORDER+1] <= -DATA_WIDTH'(666);
         for (int c = 0; c < NUM_CH; c++)
            for (int k = 0; k < ORDER; k++) begin
               r_xh[c][k] <= '0;
               r_yh[c][k] <= '0;
            end
      end else begin
         case (r_state)
            S_IDLE: begin
               if (coef_we && (int'(coef_sel) <= 2*ORDER))
                  r_coef[coef_sel] <= coef_wdata;
               // Samples for a nonexistent channel are swallowed without leaving IDLE.
               if (in_valid && (int'(in_channel) < NUM_CH)) begin
                  r_x      <= din;
                  r_ch     <= in_channel;
                  r_tap    <= '0;
                  r_acc    <= '0;
                  in_ready <= 1'b0;
                  r_state  <= S_MAC;
               end
            end
            S_MAC: begin
               if (r_tap != TAP_W'(NTAP)) begin
                  r_prod     <= w_dq;
                  r_prod_neg <= (r_tap > TAP_W'(ORDER));
                  r_tap      <= r_tap + 1'b1;
               end
               if (r_tap != '0)
                  r_acc <= w_acc_next;
               if (r_tap == TAP_W'(NTAP)) begin
                  dout        <= w_acc_next;
                  out_channel <= r_ch;
                  out_valid   <= 1'b1;
                  r_state     <= S_DONE;
                  for (int k = ORDER-1; k > 0; k--) begin
                     r_xh[r_ch][k] <= r_xh[r_ch][k-1];
                     r_yh[r_ch][k] <= r_yh[r_ch][k-1];
                  end
                  r_xh[r_ch][0] <= r_x;
                  r_yh[r_ch][0] <= w_acc_next;
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  r_state   <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule
